// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster pixel/line counters with registered sync, visible-area and start-of-line/frame decodes.
// Latency: decodes are registered from next-state counters, so they always align with Qh/Qv in the same cycle.
// Backpressure: none; enable=0 freezes all state and masks the pix_tick/line_start/frame_start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10
) (
  input  logic          reloj,
  input  logic          resetM,
  input  logic          enable,
  output logic [CW-1:0] Qh,
  output logic [CW-1:0] Qv,
  output logic          H_Sync,
  output logic          V_Sync,
  output logic          H_ON,
  output logic          V_ON,
  output logic          video_on,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q;
  logic          run_q;     // low only until the first edge after reset release
  logic          ls_q;
  logic          fs_q;
  logic          adv;
  logic          div_last;
  logic          h_last;
  logic          v_last;
  logic [CW-1:0] qh_nxt;
  logic [CW-1:0] qv_nxt;

  // run_q holds the divider for one edge after release so the first pixel
  // strobe lands exactly CLK_DIV edges after reset goes away, and keeps
  // pix_tick low while reset is asserted even when CLK_DIV is 1.
  assign adv      = enable & run_q;
  assign div_last = (div_q == DIV_LAST);
  assign h_last   = (Qh == H_LAST);
  assign v_last   = (Qv == V_LAST);

  assign pix_tick    = adv & div_last;
  assign line_start  = enable & ls_q;
  assign frame_start = enable & fs_q;

  // Next raster position; only moves on a pixel strobe.
  always_comb begin
    qh_nxt = Qh;
    qv_nxt = Qv;
    if (pix_tick) begin
      if (h_last) begin
        qh_nxt = '0;
        qv_nxt = v_last ? '0 : Qv + CW'(1);
      end else begin
        qh_nxt = Qh + CW'(1);
      end
    end
  end

  // Run flag set on the first edge after reset release.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Pixel clock divider, frozen while enable is low.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM)  div_q <= '0;
    else if (adv) div_q <= div_last ? '0 : div_q + DW'(1);
  end

  // Raster counters and frame counter.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      Qh        <= '0;
      Qv        <= '0;
      frame_cnt <= 8'd0;
    end else begin
      Qh <= qh_nxt;
      Qv <= qv_nxt;
      if (pix_tick && h_last && v_last) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Start pulses: set by the wrapping edge, cleared by the next running edge, held while frozen.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (adv) begin
      ls_q <= pix_tick & h_last;
      fs_q <= pix_tick & h_last & v_last;
    end
  end

  // Visible-area and sync decodes taken from the next counter values so they track Qh/Qv with no skew.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      H_ON     <= 1'b1;
      V_ON     <= 1'b1;
      video_on <= 1'b1;
      H_Sync   <= ~HS_POL;
      V_Sync   <= ~VS_POL;
    end else begin
      H_ON     <= (qh_nxt < H_ACT);
      V_ON     <= (qv_nxt < V_ACT);
      video_on <= (qh_nxt < H_ACT) && (qv_nxt < V_ACT);
      H_Sync   <= ((qh_nxt >= HS_BEG) && (qh_nxt <= HS_END)) ? HS_POL : ~HS_POL;
      V_Sync   <= ((qv_nxt >= VS_BEG) && (qv_nxt <= VS_END)) ? VS_POL : ~VS_POL;
    end
  end

endmodule
